// File: rtl/cpu_usm_v2.sv
// Multi-cycle RV32I core (FETCH/EXEC/MEM/HALT) with separate instruction and data ports.
// Latency: 2 cycles per non-memory instruction, 3 per load/store, with zero-wait memories.
// Backpressure: imem_req/dmem_req stay high and all outputs hold steady until the ready input; ready is ignored while req is low.
module cpu_usm_v2 #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter bit          HALT_ON_SYSTEM = 1'b1,
    parameter int          CNT_W          = 32
) (
    input  logic             clk,
    input  logic             reset,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ready,
    input  logic [31:0]      imem_rdata,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [3:0]       dmem_be,
    output logic [31:0]      dmem_addr,
    output logic [31:0]      dmem_wdata,
    input  logic             dmem_ready,
    input  logic [31:0]      dmem_rdata,
    output logic [31:0]      pc,
    output logic             retire,
    output logic [CNT_W-1:0] instret,
    output logic             halted,
    output logic             trap
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_HALT} state_t;

    state_t      state;
    logic [31:0] ir;
    logic [31:0] regs [0:31];

    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2, shamt;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] rs1v, rs2v, op_b, alu;
    logic [31:0] mem_addr, st_data, jalr_tgt, br_tgt, ld_lane, ld_data;
    logic [3:0]  mem_be;
    logic [31:0] next_pc, wr_data, rf_wdata;
    logic        wr_en, fault, is_mem, sys_halt, taken, br_ok, mem_misal, rf_we;

    // Requests follow the state; imem_req is also gated by reset so it drops the instant reset asserts
    assign imem_req  = reset && (state == S_FETCH);
    assign imem_addr = pc;
    assign dmem_req  = (state == S_MEM);

    // Field extraction, immediates and register reads (x0 always reads zero)
    always_comb begin
        opcode = ir[6:0];
        rd     = ir[11:7];
        f3     = ir[14:12];
        rs1    = ir[19:15];
        rs2    = ir[24:20];
        f7     = ir[31:25];
        imm_i  = {{20{ir[31]}}, ir[31:20]};
        imm_s  = {{20{ir[31]}}, ir[31:25], ir[11:7]};
        imm_b  = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
        imm_u  = {ir[31:12], 12'h000};
        imm_j  = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
        rs1v   = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
        rs2v   = (rs2 == 5'd0) ? 32'd0 : regs[rs2];
    end

    // Integer ALU shared by OP and OP-IMM
    always_comb begin
        op_b  = (opcode == OPC_OP) ? rs2v : imm_i;
        shamt = op_b[4:0];
        case (f3)
            3'd0:    alu = (opcode == OPC_OP && f7[5]) ? rs1v - op_b : rs1v + op_b;
            3'd1:    alu = rs1v << shamt;
            3'd2:    alu = {31'd0, $signed(rs1v) < $signed(op_b)};
            3'd3:    alu = {31'd0, rs1v < op_b};
            3'd4:    alu = rs1v ^ op_b;
            3'd5:    alu = f7[5] ? 32'($signed(rs1v) >>> shamt) : rs1v >> shamt;
            3'd6:    alu = rs1v | op_b;
            default: alu = rs1v & op_b;
        endcase
    end

    // Branch condition, load/store address, lane mapping and load data extraction
    always_comb begin
        taken = 1'b0;
        br_ok = 1'b1;
        case (f3)
            3'd0:    taken = (rs1v == rs2v);
            3'd1:    taken = (rs1v != rs2v);
            3'd4:    taken = ($signed(rs1v) < $signed(rs2v));
            3'd5:    taken = ($signed(rs1v) >= $signed(rs2v));
            3'd6:    taken = (rs1v < rs2v);
            3'd7:    taken = (rs1v >= rs2v);
            default: br_ok = 1'b0;
        endcase
        br_tgt   = pc + imm_b;
        jalr_tgt = rs1v + imm_i;
        mem_addr = rs1v + ((opcode == OPC_STORE) ? imm_s : imm_i);
        case (f3[1:0])
            2'd0: begin
                mem_be    = 4'b0001 << mem_addr[1:0];
                st_data   = {4{rs2v[7:0]}};
                mem_misal = 1'b0;
            end
            2'd1: begin
                mem_be    = 4'b0011 << mem_addr[1:0];
                st_data   = {2{rs2v[15:0]}};
                mem_misal = mem_addr[0];
            end
            default: begin
                mem_be    = 4'b1111;
                st_data   = rs2v;
                mem_misal = (mem_addr[1:0] != 2'b00);
            end
        endcase
        ld_lane = dmem_rdata >> {dmem_addr[1:0], 3'b000};
        case (f3)
            3'd0:    ld_data = {{24{ld_lane[7]}}, ld_lane[7:0]};
            3'd1:    ld_data = {{16{ld_lane[15]}}, ld_lane[15:0]};
            3'd4:    ld_data = {24'd0, ld_lane[7:0]};
            3'd5:    ld_data = {16'd0, ld_lane[15:0]};
            default: ld_data = ld_lane;
        endcase
    end

    // EXEC decision: next pc, register write, memory hand-off, faults and SYSTEM halt
    always_comb begin
        next_pc  = pc + 32'd4;
        wr_en    = 1'b0;
        wr_data  = alu;
        fault    = 1'b0;
        is_mem   = 1'b0;
        sys_halt = 1'b0;
        case (opcode)
            OPC_LUI: begin
                wr_en   = 1'b1;
                wr_data = imm_u;
            end
            OPC_AUIPC: begin
                wr_en   = 1'b1;
                wr_data = pc + imm_u;
            end
            OPC_JAL: begin
                wr_en   = 1'b1;
                wr_data = pc + 32'd4;
                next_pc = pc + imm_j;
                fault   = next_pc[1];
            end
            OPC_JALR: begin
                wr_en   = 1'b1;
                wr_data = pc + 32'd4;
                next_pc = {jalr_tgt[31:1], 1'b0};
                fault   = jalr_tgt[1] || (f3 != 3'd0);
            end
            OPC_BRANCH: begin
                if (taken) next_pc = br_tgt;
                fault = !br_ok || (taken && br_tgt[1]);
            end
            OPC_LOAD: begin
                is_mem = 1'b1;
                fault  = mem_misal || (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
            end
            OPC_STORE: begin
                is_mem = 1'b1;
                fault  = mem_misal || f3[2] || (f3 == 3'd3);
            end
            OPC_OPIMM: begin
                wr_en = 1'b1;
                if (f3 == 3'd1)      fault = (f7 != 7'h00);
                else if (f3 == 3'd5) fault = (f7 != 7'h00) && (f7 != 7'h20);
            end
            OPC_OP: begin
                wr_en = 1'b1;
                fault = !((f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
            end
            OPC_FENCE: ;
            OPC_SYSTEM: begin
                if (HALT_ON_SYSTEM) begin
                    sys_halt = 1'b1;
                    next_pc  = pc;
                end
            end
            default: fault = 1'b1;
        endcase
        if (fault) wr_en = 1'b0;
    end

    // Register-file write port: ALU/jump results in EXEC, load data when MEM completes
    always_comb begin
        rf_we    = 1'b0;
        rf_wdata = wr_data;
        if (state == S_EXEC) begin
            rf_we = wr_en && (rd != 5'd0);
        end else if (state == S_MEM) begin
            rf_we    = dmem_ready && !dmem_we && (rd != 5'd0);
            rf_wdata = ld_data;
        end
    end

    // Register file storage, intentionally not reset
    always_ff @(posedge clk) begin
        if (rf_we) regs[rd] <= rf_wdata;
    end

    // Control FSM with registered pc, retire pulse, counter and status outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_FETCH;
            pc         <= RESET_PC;
            ir         <= 32'd0;
            retire     <= 1'b0;
            instret    <= '0;
            halted     <= 1'b0;
            trap       <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_be    <= 4'd0;
            dmem_addr  <= 32'd0;
            dmem_wdata <= 32'd0;
        end else begin
            retire <= 1'b0;
            case (state)
                S_FETCH: begin
                    if (imem_ready) begin
                        ir    <= imem_rdata;
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (fault) begin
                        state  <= S_HALT;
                        halted <= 1'b1;
                        trap   <= 1'b1;
                    end else if (is_mem) begin
                        dmem_we    <= (opcode == OPC_STORE);
                        dmem_be    <= mem_be;
                        dmem_addr  <= mem_addr;
                        dmem_wdata <= st_data;
                        state      <= S_MEM;
                    end else begin
                        pc      <= next_pc;
                        retire  <= 1'b1;
                        instret <= instret + CNT_W'(1);
                        halted  <= sys_halt;
                        state   <= sys_halt ? S_HALT : S_FETCH;
                    end
                end
                S_MEM: begin
                    if (dmem_ready) begin
                        pc      <= pc + 32'd4;
                        retire  <= 1'b1;
                        instret <= instret + CNT_W'(1);
                        state   <= S_FETCH;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_usm_v2.sv
// Program-level bench for cpu_usm_v2 with modelled instruction/data memories.
// Latency: retire cycles and instret steps are scored against expected queues.
// Backpressure: memory models insert programmable stall cycles before ready.
module tb_cpu_usm_v2;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             imem_req, imem_ready;
    logic [31:0]      imem_addr, imem_rdata;
    logic             dmem_req, dmem_we, dmem_ready;
    logic [3:0]       dmem_be;
    logic [31:0]      dmem_addr, dmem_wdata, dmem_rdata;
    logic [31:0]      pc;
    logic             retire, halted, trap;
    logic [CNT_W-1:0] instret;

    cpu_usm_v2 #(.RESET_PC(32'h0), .HALT_ON_SYSTEM(1'b1), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_be(dmem_be), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
        .pc(pc), .retire(retire), .instret(instret), .halted(halted), .trap(trap)
    );

    initial forever #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          stall;
    } dexp_t;

    dexp_t       dmem_q[$];
    int          ret_exp[$];
    dexp_t       cur;
    logic [31:0] imem [0:63];
    int          n_cmp = 0, n_err = 0;
    int          cyc = 0, ret_cnt = 0, istall = 0, d_left = 0;
    bit          d_active = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Instruction encoders
    function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3, input int rd, input int op);
        logic [31:0] v, a, f, d, o;
        v = imm; a = rs1; f = f3; d = rd; o = op;
        return {v[11:0], a[4:0], f[2:0], d[4:0], o[6:0]};
    endfunction
    function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1, input int f3);
        logic [31:0] v, b, a, f;
        v = imm; b = rs2; a = rs1; f = f3;
        return {v[11:5], b[4:0], a[4:0], f[2:0], v[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input int f3);
        logic [31:0] v, b, a, f;
        v = imm; b = rs2; a = rs1; f = f3;
        return {v[12], v[10:5], b[4:0], a[4:0], f[2:0], v[4:1], v[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] enc_j(input int imm, input int rd);
        logic [31:0] v, d;
        v = imm; d = rd;
        return {v[20], v[10:1], v[11], v[19:12], d[4:0], 7'b1101111};
    endfunction
    function automatic logic [31:0] enc_u(input int imm20, input int rd, input int op);
        logic [31:0] v, d, o;
        v = imm20; d = rd; o = op;
        return {v[19:0], d[4:0], o[6:0]};
    endfunction
    function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
        return enc_i(imm, rs1, 0, rd, 7'h13);
    endfunction
    localparam logic [31:0] ECALL = 32'h0000_0073;

    task automatic push_st(input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd, input int st);
        dmem_q.push_back('{we: 1'b1, be: be, addr: a, wdata: wd, rdata: 32'd0, stall: st});
    endtask
    task automatic push_ld(input logic [31:0] a, input logic [31:0] rd, input int st);
        dmem_q.push_back('{we: 1'b0, be: 4'd0, addr: a, wdata: 32'd0, rdata: rd, stall: st});
    endtask

    task automatic clear_imem();
        for (int i = 0; i < 64; i++) imem[i] = 32'd0;
    endtask

    task automatic check_dmem(input string pfx);
        chk({pfx, "_we"}, 32'(dmem_we), 32'(cur.we));
        chk({pfx, "_addr"}, dmem_addr, cur.addr);
        if (cur.we) begin
            chk({pfx, "_be"}, 32'(dmem_be), 32'(cur.be));
            chk({pfx, "_wdata"}, dmem_wdata, cur.wdata);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Instruction memory responder with optional initial stall
    initial forever begin
        @(negedge clk);
        if (!reset) begin
            imem_ready = 1'b0;
        end else if (istall > 0) begin
            chk("istall_req", 32'(imem_req), 32'd1);
            chk("istall_addr", imem_addr, 32'd0);
            chk("istall_retire", 32'(retire), 32'd0);
            istall--;
            imem_ready = 1'b0;
        end else if (imem_req) begin
            imem_ready = 1'b1;
            imem_rdata = imem[imem_addr[7:2]];
        end else begin
            imem_ready = 1'b0;
        end
    end

    // Data memory responder: pops the expected access, checks it every request cycle
    initial forever begin
        @(negedge clk);
        if (!reset) begin
            dmem_ready = 1'b0;
            d_active   = 1'b0;
        end else if (dmem_req) begin
            dmem_ready = 1'b0;
            if (!d_active) begin
                if (dmem_q.size() == 0) begin
                    chk("dmem_unexpected_req", 32'(dmem_req), 32'd0);
                end else begin
                    cur      = dmem_q.pop_front();
                    d_active = 1'b1;
                    d_left   = cur.stall;
                    check_dmem("dmem");
                end
            end else begin
                check_dmem("dmem_hold");
            end
            if (d_active) begin
                if (d_left > 0) begin
                    d_left--;
                end else begin
                    dmem_ready = 1'b1;
                    dmem_rdata = cur.rdata;
                    d_active   = 1'b0;
                end
            end
        end else begin
            dmem_ready = 1'b0;
        end
    end

    // Retire monitor: instret must track retires, and timing matches any queued expectation
    initial forever begin
        @(negedge clk);
        if (reset && retire) begin
            ret_cnt++;
            chk("instret_step", 32'(instret), 32'(ret_cnt % (1 << CNT_W)));
            if (ret_exp.size() > 0) chk("retire_cycle", cyc, ret_exp.pop_front());
        end
    end

    task automatic check_reset_state();
        #1;
        chk("rst_imem_req", 32'(imem_req), 32'd0);
        chk("rst_dmem_req", 32'(dmem_req), 32'd0);
        chk("rst_retire", 32'(retire), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_trap", 32'(trap), 32'd0);
        chk("rst_instret", 32'(instret), 32'd0);
        chk("rst_pc", pc, 32'd0);
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clk);
        #1;
        reset   = 1'b1;
        cyc     = 0;
        ret_cnt = 0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        dmem_q.delete();
        ret_exp.delete();
        istall = 0;
        check_reset_state();
        release_reset();
    endtask

    task automatic finish_prog(input logic [31:0] exp_pc, input int exp_cnt, input logic exp_trap);
        int n;
        n = 0;
        while (!halted && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("halted", 32'(halted), 32'd1);
        chk("trap", 32'(trap), 32'(exp_trap));
        chk("pc_at_halt", pc, exp_pc);
        chk("instret_final", 32'(instret), 32'(exp_cnt % (1 << CNT_W)));
        repeat (5) @(negedge clk);
        chk("halt_pc_hold", pc, exp_pc);
        chk("halt_imem_req", 32'(imem_req), 32'd0);
        chk("halt_dmem_req", 32'(dmem_req), 32'd0);
        chk("halt_instret_hold", 32'(instret), 32'(exp_cnt % (1 << CNT_W)));
        chk("sb_dmem_left", dmem_q.size(), 32'd0);
        chk("sb_retire_left", ret_exp.size(), 32'd0);
    endtask

    task automatic load_prog_a();
        clear_imem();
        imem[0] = addi(1, 0, 5);
        imem[1] = addi(2, 1, -7);
        imem[2] = enc_s(0, 2, 0, 2);
        imem[3] = ECALL;
    endtask

    initial begin
        int n;
        imem_ready = 1'b0;
        imem_rdata = 32'd0;
        dmem_ready = 1'b0;
        dmem_rdata = 32'd0;
        clear_imem();
        #3;

        // Basic two-addi sequence with zero-wait memories
        load_prog_a();
        do_reset();
        push_st(32'h0, 4'hF, 32'hFFFF_FFFE, 0);
        ret_exp = '{2, 4, 7, 9};
        finish_prog(32'd12, 4, 1'b0);

        // Same program with the first fetch stalled five cycles
        do_reset();
        istall = 5;
        push_st(32'h0, 4'hF, 32'hFFFF_FFFE, 0);
        ret_exp = '{7, 9, 12, 14};
        finish_prog(32'd12, 4, 1'b0);

        // Loads/stores on every lane, then a misaligned word load that traps
        clear_imem();
        imem[0] = addi(1, 0, 32'h100);
        imem[1] = enc_i(1, 1, 0, 2, 7'h03);
        imem[2] = enc_i(2, 1, 5, 3, 7'h03);
        imem[3] = enc_s(3, 2, 1, 0);
        imem[4] = enc_s(0, 3, 0, 2);
        imem[5] = enc_s(2, 2, 1, 1);
        imem[6] = enc_i(2, 0, 2, 2, 7'h03);
        do_reset();
        push_ld(32'h101, 32'h8081_8283, 2);
        push_ld(32'h102, 32'h8081_8283, 0);
        push_st(32'h103, 4'b1000, 32'h8282_8282, 1);
        push_st(32'h000, 4'b1111, 32'h0000_8081, 0);
        push_st(32'h102, 4'b1100, 32'hFF82_FF82, 0);
        finish_prog(32'd24, 6, 1'b1);

        // Branch loop, JAL, AUIPC and LUI observed through stores
        clear_imem();
        imem[0]  = addi(1, 0, 3);
        imem[1]  = addi(1, 1, -1);
        imem[2]  = enc_b(-4, 0, 1, 1);
        imem[3]  = enc_j(8, 3);
        imem[4]  = addi(4, 0, 99);
        imem[5]  = enc_s(32'h40, 3, 0, 2);
        imem[6]  = enc_u(0, 5, 7'h17);
        imem[7]  = enc_s(32'h44, 5, 0, 2);
        imem[8]  = enc_u(32'h12345, 6, 7'h37);
        imem[9]  = enc_s(32'h48, 6, 0, 2);
        imem[10] = ECALL;
        do_reset();
        push_st(32'h40, 4'hF, 32'd16, 0);
        push_st(32'h44, 4'hF, 32'd24, 0);
        push_st(32'h48, 4'hF, 32'h1234_5000, 0);
        finish_prog(32'd40, 14, 1'b0);

        // Sixteen retires: self-increment chain, counter wraps to zero on the ecall
        clear_imem();
        imem[0] = addi(1, 0, 0);
        for (int i = 1; i <= 13; i++) imem[i] = addi(1, 1, 1);
        imem[14] = enc_s(0, 1, 0, 2);
        imem[15] = ECALL;
        do_reset();
        push_st(32'h0, 4'hF, 32'd13, 0);
        finish_prog(32'd60, 16, 1'b0);

        // JAL to a target with bit1 set traps without retiring
        clear_imem();
        imem[0] = enc_j(6, 1);
        do_reset();
        finish_prog(32'd0, 0, 1'b1);

        // Illegal opcode traps
        clear_imem();
        imem[0] = addi(1, 0, 1);
        imem[1] = 32'hFFFF_FFFF;
        do_reset();
        finish_prog(32'd4, 1, 1'b1);

        // Reset asserted while a store is stalled in MEM
        clear_imem();
        imem[0] = enc_s(4, 0, 0, 2);
        imem[1] = ECALL;
        do_reset();
        push_st(32'h4, 4'hF, 32'd0, 1000);
        n = 0;
        while (!dmem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("mid_mem_req_seen", 32'(dmem_req), 32'd1);
        repeat (3) @(negedge clk);
        #2;
        reset = 1'b0;
        dmem_q.delete();
        d_active = 1'b0;
        check_reset_state();
        release_reset();
        #1;
        chk("post_rst_imem_req", 32'(imem_req), 32'd1);
        chk("post_rst_imem_addr", imem_addr, 32'd0);
        push_st(32'h4, 4'hF, 32'd0, 0);
        finish_prog(32'd4, 2, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
